// File: rtl/apb_i2c_initiator.sv
// Command-FIFO driven APB2 initiator for an I2C core register file.
// Executes queued APB reads/writes and wait-for-interrupt commands.
module apb_i2c_initiator #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [8:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [8:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       INT
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [15:0] TO_LAST = TIMEOUT_CYCLES - 16'd1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT_INT} state_t;

    state_t        state_q, state_d;
    logic [18:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [8:0]    paddr_q, paddr_d;
    logic [7:0]    pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          push, pop, load, not_empty;
    logic [18:0]   head;
    logic [1:0]    head_op;

    assign push      = cmd_valid && cmd_ready_q;
    assign not_empty = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign head_op   = head[18:17];

    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_wdata};
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pop           = 1'b0;
        load          = 1'b0;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (not_empty) begin
                    pop = 1'b1;
                    case (head_op)
                        2'b00, 2'b01: load = 1'b1;
                        2'b10: begin
                            state_d = WAIT_INT;
                            cnt_d   = 16'd0;
                        end
                        default: ;
                    endcase
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                state_d = IDLE;
                if (!pwrite_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = PRDATA;
                end
                // chain straight into the next transfer when one is queued
                if (not_empty && !head_op[1]) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end
            end
            WAIT_INT: begin
                if (INT) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 8'h00;
                end else if (cnt_q == TO_LAST) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 8'h00;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
        if (load) begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = head[16:8];
            pwrite_d = ~head_op[0];
            if (~head_op[0]) pwdata_d = head[7:0];
        end
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        cmd_ready_d = (count_d < DEPTH);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b0;
            cnt_q         <= 16'd0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 9'h000;
            pwdata_q      <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = (state_q != IDLE) || not_empty;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_i2c_initiator.sv
// Scoreboard bench for apb_i2c_initiator: directed commands push expected
// APB transfers and responses; a negedge monitor pops and compares them.
module tb_apb_i2c_initiator;
    localparam logic [15:0] TO = 16'd20;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [8:0] cmd_addr = 9'h000;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic       busy;
    logic       PSEL, PENABLE, PWRITE;
    logic [8:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       INT = 1'b0;
    logic [7:0] regs [512];

    apb_i2c_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .INT(INT)
    );

    always #5 PCLK = ~PCLK;
    assign PRDATA = regs[PADDR];

    // cyc = number of rising edges so far; cycle c is the period ending at edge c
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic       wr;
        logic [8:0] addr;
        logic [7:0] wdata;
        int         setup_at;
        bit         b2b;
    } apb_t;
    typedef struct {
        logic [7:0] rdata;
        logic       tmo;
        int         at;
    } rsp_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   setup_seen = 0;
    int   rsp_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", nm, act, exp);
        end
    endtask

    apb_t cur_e;
    bit   have_e = 1'b0;
    bit   prev_en = 1'b0;
    bit   prev_setup = 1'b0;
    int   last_acc = -10;

    always @(negedge PCLK) begin
        int   cur;
        rsp_t r;
        cur = cyc + 1;
        chk("apb_enable_rule", 32'(PENABLE && (!PSEL || prev_en)), 32'd0);
        if (PSEL && !PENABLE) begin
            setup_seen++;
            if (apb_q.size() == 0) begin
                checks++;
                errors++;
                have_e = 1'b0;
                $display("FAIL unexpected_setup: got addr 'h%0h, required none",
                         PADDR);
            end else begin
                cur_e  = apb_q.pop_front();
                have_e = 1'b1;
                chk("setup_addr", 32'(PADDR), 32'(cur_e.addr));
                chk("setup_write", 32'(PWRITE), 32'(cur_e.wr));
                if (cur_e.wr)
                    chk("setup_wdata", 32'(PWDATA), 32'(cur_e.wdata));
                if (cur_e.setup_at >= 0)
                    chk("setup_cycle", 32'(cur), 32'(cur_e.setup_at));
                if (cur_e.b2b)
                    chk("no_idle_gap", 32'(last_acc), 32'(cur - 1));
            end
        end
        if (PSEL && PENABLE) begin
            chk("access_after_setup", 32'(prev_setup), 32'd1);
            if (have_e) begin
                chk("access_addr", 32'(PADDR), 32'(cur_e.addr));
                chk("access_write", 32'(PWRITE), 32'(cur_e.wr));
                if (cur_e.wr)
                    chk("access_wdata", 32'(PWDATA), 32'(cur_e.wdata));
            end
            have_e   = 1'b0;
            last_acc = cur;
        end
        if (rsp_valid) begin
            rsp_seen++;
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 'h%0h, required none",
                         rsp_rdata);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(r.tmo));
                if (r.at >= 0) chk("rsp_cycle", 32'(cur), 32'(r.at));
            end
        end
        prev_en    = PENABLE;
        prev_setup = PSEL && !PENABLE;
    end

    task automatic push_cmd(input logic [1:0] op, input logic [8:0] a,
                            input logic [7:0] d, output int n);
        int t = 0;
        @(negedge PCLK);
        while (!cmd_ready && t < 100) begin
            @(negedge PCLK);
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_ready_timeout: got cmd_ready 0, required 1");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge PCLK);
        #1;
        n         = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        repeat (2) @(negedge PCLK);
        while ((busy || rsp_q.size() != 0) && t < 200) begin
            @(negedge PCLK);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy %0d, required 0", busy);
        end
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        int n, n0, t, s0, r0;
        for (int i = 0; i < 512; i++) regs[i] = 8'h00;
        regs[9'h004] = 8'hF8;
        regs[9'h011] = 8'h3C;
        regs[9'h1FF] = 8'h81;

        repeat (3) @(negedge PCLK);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_psel", 32'(PSEL), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        PRESETN = 1'b1;
        @(posedge PCLK);
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        push_cmd(2'b00, 9'h008, 8'h45, n);
        apb_q.push_back('{1'b1, 9'h008, 8'h45, n + 2, 1'b0});
        chk("busy_after_push", 32'(busy), 32'd1);
        wait_idle();

        push_cmd(2'b01, 9'h004, 8'h00, n);
        apb_q.push_back('{1'b0, 9'h004, 8'h00, n + 2, 1'b0});
        rsp_q.push_back('{8'hF8, 1'b0, n + 4});
        wait_idle();

        push_cmd(2'b00, 9'h010, 8'hA5, n);
        apb_q.push_back('{1'b1, 9'h010, 8'hA5, n + 2, 1'b0});
        push_cmd(2'b01, 9'h011, 8'h00, n);
        apb_q.push_back('{1'b0, 9'h011, 8'h00, -1, 1'b1});
        rsp_q.push_back('{8'h3C, 1'b0, -1});
        push_cmd(2'b11, 9'h055, 8'h66, n);
        push_cmd(2'b01, 9'h1FF, 8'h00, n);
        apb_q.push_back('{1'b0, 9'h1FF, 8'h00, -1, 1'b0});
        rsp_q.push_back('{8'h81, 1'b0, -1});
        wait_idle();

        push_cmd(2'b10, 9'h000, 8'h00, n);
        repeat (10) @(negedge PCLK);
        rsp_q.push_back('{8'h00, 1'b0, cyc + 2});
        INT = 1'b1;
        @(posedge PCLK);
        #1;
        INT = 1'b0;
        wait_idle();

        push_cmd(2'b10, 9'h000, 8'h00, n);
        rsp_q.push_back('{8'h00, 1'b1, n + 22});
        wait_idle();

        push_cmd(2'b10, 9'h000, 8'h00, n0);
        rsp_q.push_back('{8'h00, 1'b0, -1});
        for (int i = 0; i < 4; i++) begin
            push_cmd(2'b00, 9'(9'h0A0 + i), 8'(8'h10 + i), n);
            apb_q.push_back('{1'b1, 9'(9'h0A0 + i), 8'(8'h10 + i), -1, i != 0});
        end
        chk("full_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = 9'h1EE;
        cmd_wdata = 8'hEE;
        repeat (2) @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        chk("full_still_waiting", 32'(busy && !PSEL), 32'd1);
        @(negedge PCLK);
        INT = 1'b1;
        @(posedge PCLK);
        #1;
        INT = 1'b0;
        wait_idle();

        push_cmd(2'b01, 9'h004, 8'h00, n);
        apb_q.push_back('{1'b0, 9'h004, 8'h00, n + 2, 1'b0});
        push_cmd(2'b00, 9'h020, 8'h77, n);
        push_cmd(2'b01, 9'h011, 8'h00, n);
        t = 0;
        do begin
            @(negedge PCLK);
            t++;
        end while (!(PSEL && PENABLE) && t < 50);
        chk("reset_access_found", 32'(PSEL && PENABLE), 32'd1);
        #2;
        PRESETN = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_pwrite", 32'(PWRITE), 32'd0);
        chk("arst_paddr", 32'(PADDR), 32'd0);
        chk("arst_pwdata", 32'(PWDATA), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("arst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        apb_q.delete();
        rsp_q.delete();
        s0 = setup_seen;
        r0 = rsp_seen;
        repeat (3) @(negedge PCLK);
        PRESETN = 1'b1;
        repeat (20) @(negedge PCLK);
        chk("post_reset_no_setup", 32'(setup_seen - s0), 32'd0);
        chk("post_reset_no_rsp", 32'(rsp_seen - r0), 32'd0);
        chk("post_reset_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_idle", 32'(busy), 32'd0);

        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("apb_q_drained", 32'(apb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
